cnt_frame_sequencer: RTL and testbench

- Frame-acquisition controller for NCH instances of the pixel-event counter.
- Each frame runs in order: clear the counters, open the count gate for a programmed number of refClock cycles, close it, and strobe the counters' read input.
- It then snapshots all NCH 32-bit counter outputs and streams them to the readout logic over a valid/ready interface, for one frame, N frames or free-run.

---
 rtl/cnt_frame_sequencer_pkg.sv | 23 ++
 rtl/cnt_frame_sequencer_snapshot_mux.sv | 64 ++++++
 rtl/cnt_frame_sequencer.sv | 171 +++++++++++++++++
 tb/tb_cnt_frame_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_frame_sequencer_pkg.sv
// rtl/cnt_frame_sequencer_pkg.sv - shared FSM encoding and constants for the frame sequencer
package cnt_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    CNT_FSM_IDLE   = 3'd0,
    CNT_FSM_CLEAR  = 3'd1,
    CNT_FSM_GATE   = 3'd2,
    CNT_FSM_LATCH  = 3'd3,
    CNT_FSM_SETTLE = 3'd4,
    CNT_FSM_SNAP   = 3'd5,
    CNT_FSM_DRAIN  = 3'd6
  } cnt_fsm_e;

  localparam int CNT_W         = 32;
  localparam int RST_HOLD_DEF  = 2;
  localparam int READ_HOLD_DEF = 4;
  localparam int SETTLE_DEF    = 4;

  function automatic int at_least(input int v, input int lo);
    return (v < lo) ? lo : v;
  endfunction

endpackage

// File: rtl/cnt_frame_sequencer_snapshot_mux.sv
// rtl/cnt_frame_sequencer_snapshot_mux.sv - snapshot register array and valid/ready word streamer
module cnt_snapshot_mux
  import cnt_frame_sequencer_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [NCH*32-1:0]  i_cnt_data,
  input  logic [15:0]        i_frame,
  input  logic               i_data_ready,
  output logic [CNT_W-1:0]   o_data_out,
  output logic [3:0]         o_data_ch,
  output logic [15:0]        o_data_frame,
  output logic               o_data_last,
  output logic               o_data_valid,
  output logic               o_drain_done
);

  localparam logic [3:0] LAST_CH = 4'(NCH - 1);

  // Channel 0 always sits in the low word; accepting a word shifts the next one down.
  logic [NCH*32-1:0] r_snap;
  logic [3:0]        r_ch;
  logic [15:0]       r_frame;
  logic              r_last;
  logic              r_valid;
  logic              w_accept;

  assign w_accept     = r_valid && i_data_ready;
  assign o_drain_done = w_accept && r_last;
  assign o_data_out   = r_snap[CNT_W-1:0];
  assign o_data_ch    = r_ch;
  assign o_data_frame = r_frame;
  assign o_data_last  = r_last;
  assign o_data_valid = r_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_snap  <= '0;
      r_ch    <= '0;
      r_frame <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_snap  <= i_cnt_data;
      r_ch    <= '0;
      r_frame <= i_frame;
      r_last  <= (LAST_CH == 4'd0);
      r_valid <= 1'b1;
    end else if (w_accept) begin
      if (r_last) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        r_snap <= r_snap >> CNT_W;
        r_ch   <= r_ch + 4'd1;
        r_last <= ((r_ch + 4'd1) == LAST_CH);
      end
    end
  end

endmodule

// File: rtl/cnt_frame_sequencer.sv
// rtl/cnt_frame_sequencer.sv - frame acquisition controller: clear, gate, latch, settle, snapshot, drain
module cnt_frame_sequencer
  import cnt_frame_sequencer_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int RST_HOLD  = RST_HOLD_DEF,
  parameter int READ_HOLD = READ_HOLD_DEF,
  parameter int SETTLE    = SETTLE_DEF
) (
  input  logic               i_ref_clock,
  input  logic               i_rst_ctrl,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [31:0]        i_gate_len,
  input  logic [15:0]        i_num_frames,
  input  logic [NCH*32-1:0]  i_cnt_data,
  output logic               o_cnt_rst,
  output logic               o_cnt_en_n,
  output logic               o_cnt_read,
  output logic [31:0]        o_data_out,
  output logic [3:0]         o_data_ch,
  output logic [15:0]        o_data_frame,
  output logic               o_data_last,
  output logic               o_data_valid,
  input  logic               i_data_ready,
  output logic               o_busy,
  output logic               o_frame_done
);

  localparam logic [31:0] RST_LD    = 32'(at_least(RST_HOLD, 1) - 1);
  localparam logic [31:0] READ_LD   = 32'(at_least(READ_HOLD, 2) - 1);
  localparam logic [31:0] SETTLE_LD = 32'(at_least(SETTLE, 4) - 1);

  cnt_fsm_e    r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_gate_len;
  logic [15:0] r_num_frames;
  logic [15:0] r_frame;
  logic [15:0] w_frame_inc;
  logic        r_stop_pend;
  logic        w_stop_eff;
  logic        w_drain_done;
  logic        w_load;
  logic        w_run_start;

  assign w_frame_inc = r_frame + 16'd1;
  assign w_stop_eff  = r_stop_pend || i_stop;
  assign w_load      = (r_state == CNT_FSM_SNAP);
  assign w_run_start = (r_state == CNT_FSM_IDLE) && (w_state_nxt == CNT_FSM_CLEAR);

  // r_cnt counts down the remaining cycles of the timed states; exit when it reaches 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CNT_FSM_IDLE: begin
        if (i_start && !i_stop) begin
          w_state_nxt = CNT_FSM_CLEAR;
          w_cnt_nxt   = RST_LD;
        end
      end
      CNT_FSM_CLEAR: begin
        if (i_stop) begin
          w_state_nxt = CNT_FSM_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = CNT_FSM_GATE;
          w_cnt_nxt   = (r_gate_len == '0) ? '0 : r_gate_len - 32'd1;
        end else begin
          w_cnt_nxt = r_cnt - 32'd1;
        end
      end
      CNT_FSM_GATE: begin
        if (i_stop) begin
          w_state_nxt = CNT_FSM_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = CNT_FSM_LATCH;
          w_cnt_nxt   = READ_LD;
        end else begin
          w_cnt_nxt = r_cnt - 32'd1;
        end
      end
      CNT_FSM_LATCH: begin
        if (r_cnt == '0) begin
          w_state_nxt = CNT_FSM_SETTLE;
          w_cnt_nxt   = SETTLE_LD;
        end else begin
          w_cnt_nxt = r_cnt - 32'd1;
        end
      end
      CNT_FSM_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = CNT_FSM_SNAP;
        end else begin
          w_cnt_nxt = r_cnt - 32'd1;
        end
      end
      CNT_FSM_SNAP: begin
        w_state_nxt = CNT_FSM_DRAIN;
      end
      CNT_FSM_DRAIN: begin
        if (w_drain_done) begin
          if (w_stop_eff || (r_num_frames != '0 && w_frame_inc == r_num_frames)) begin
            w_state_nxt = CNT_FSM_IDLE;
          end else begin
            w_state_nxt = CNT_FSM_CLEAR;
            w_cnt_nxt   = RST_LD;
          end
        end
      end
      default: begin
        w_state_nxt = CNT_FSM_IDLE;
      end
    endcase
  end

  // Control outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge i_ref_clock) begin
    if (i_rst_ctrl) begin
      r_state      <= CNT_FSM_IDLE;
      r_cnt        <= '0;
      r_gate_len   <= '0;
      r_num_frames <= '0;
      r_frame      <= '0;
      r_stop_pend  <= 1'b0;
      o_cnt_rst    <= 1'b0;
      o_cnt_en_n   <= 1'b1;
      o_cnt_read   <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_run_start) begin
        r_gate_len   <= i_gate_len;
        r_num_frames <= i_num_frames;
        r_frame      <= '0;
      end else if (w_drain_done) begin
        r_frame <= w_frame_inc;
      end
      if (w_state_nxt == CNT_FSM_IDLE) begin
        r_stop_pend <= 1'b0;
      end else if (i_stop && r_state inside {CNT_FSM_LATCH, CNT_FSM_SETTLE,
                                             CNT_FSM_SNAP, CNT_FSM_DRAIN}) begin
        r_stop_pend <= 1'b1;
      end
      o_cnt_rst    <= (w_state_nxt == CNT_FSM_CLEAR);
      o_cnt_en_n   <= (w_state_nxt != CNT_FSM_GATE);
      o_cnt_read   <= (w_state_nxt == CNT_FSM_LATCH);
      o_busy       <= (w_state_nxt != CNT_FSM_IDLE);
      o_frame_done <= w_drain_done;
    end
  end

  cnt_snapshot_mux #(
    .NCH (NCH)
  ) u_snapshot_mux (
    .i_clk        (i_ref_clock),
    .i_rst        (i_rst_ctrl),
    .i_load       (w_load),
    .i_cnt_data   (i_cnt_data),
    .i_frame      (r_frame),
    .i_data_ready (i_data_ready),
    .o_data_out   (o_data_out),
    .o_data_ch    (o_data_ch),
    .o_data_frame (o_data_frame),
    .o_data_last  (o_data_last),
    .o_data_valid (o_data_valid),
    .o_drain_done (w_drain_done)
  );

endmodule

// File: tb/tb_cnt_frame_sequencer.sv
// tb/tb_cnt_frame_sequencer.sv - scoreboard bench for cnt_frame_sequencer
module tb_cnt_frame_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stop;
  logic [31:0]  gate_len;
  logic [15:0]  num_frames;
  logic [127:0] cnt_data;
  logic         cnt_rst;
  logic         cnt_en_n;
  logic         cnt_read;
  logic [31:0]  data_out;
  logic [3:0]   data_ch;
  logic [15:0]  data_frame;
  logic         data_last;
  logic         data_valid;
  logic         data_ready = 1'b1;
  logic         busy;
  logic         frame_done;

  int n_checks = 0;
  int n_err    = 0;
  int n_acc    = 0;
  int n_fd     = 0;
  int gate_run = 0;
  int read_run = 0;
  int last_gate = 0;
  int last_read = 0;

  logic [3:0]   rdy_pat = 4'hF;
  logic         use_model = 1'b0;
  logic [31:0]  m_cnt [4];
  logic [52:0]  exp_q [$];

  always #5 clk = ~clk;

  cnt_frame_sequencer dut (
    .i_ref_clock  (clk),
    .i_rst_ctrl   (rst),
    .i_start      (start),
    .i_stop       (stop),
    .i_gate_len   (gate_len),
    .i_num_frames (num_frames),
    .i_cnt_data   (cnt_data),
    .o_cnt_rst    (cnt_rst),
    .o_cnt_en_n   (cnt_en_n),
    .o_cnt_read   (cnt_read),
    .o_data_out   (data_out),
    .o_data_ch    (data_ch),
    .o_data_frame (data_frame),
    .o_data_last  (data_last),
    .o_data_valid (data_valid),
    .i_data_ready (data_ready),
    .o_busy       (busy),
    .o_frame_done (frame_done)
  );

  // Counter model: channel k adds k+1 per enabled cycle, cleared by cnt_rst.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (cnt_rst) m_cnt[k] <= 32'd0;
      else if (!cnt_en_n) m_cnt[k] <= m_cnt[k] + 32'(k + 1);
    end
  end

  assign cnt_data = use_model ? {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]}
                              : {32'd8, 32'd7, 32'd6, 32'd5};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_words(input logic [15:0] fr, input logic [31:0] base,
                            input logic [31:0] step, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back({base + 32'(k) * step, 4'(k), fr, (k == 3)});
  endtask

  task automatic pulse_start(input logic [31:0] gl, input logic [15:0] nf);
    @(negedge clk);
    gate_len = gl;
    num_frames = nf;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(nm, 64'(n < 5000), 64'd1);
  endtask

  task automatic check_reset_outputs(input string nm);
    check(nm, {cnt_rst, cnt_en_n, cnt_read, data_valid, data_last, busy, frame_done,
               data_out, data_ch, data_frame},
              {1'b0, 1'b1, 5'b0, 32'd0, 4'd0, 16'd0});
  endtask

  initial begin
    rdy_pat = 4'hF;
    for (int i = 0; ; i = (i + 1) % 4) begin
      @(posedge clk);
      #1;
      data_ready = rdy_pat[i];
    end
  end

  // Monitor: pops the scoreboard on every accepted word and checks stall stability.
  initial begin
    logic        prev_stall;
    logic [52:0] prev_word;
    logic [52:0] cur;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      cur = {data_out, data_ch, data_frame, data_last};
      if (prev_stall) check("hold_word", {data_valid, cur}, {1'b1, prev_word});
      if (data_valid && data_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_word: got %0h expected none", cur);
        end else begin
          check("word", cur, exp_q.pop_front());
        end
      end
      prev_stall = data_valid && !data_ready;
      prev_word  = cur;
      if (frame_done) n_fd++;
      if (!cnt_en_n) gate_run++;
      else if (gate_run != 0) begin last_gate = gate_run; gate_run = 0; end
      if (cnt_read) read_run++;
      else if (read_run != 0) begin last_read = read_run; read_run = 0; end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int fd0;
    int acc0;
    int n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; gate_len = '0; num_frames = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // Single frame with fixed counts.
    fd0 = n_fd;
    push_words(16'd0, 32'd5, 32'd1, 4);
    pulse_start(32'd10, 16'd1);
    wait_idle("t1_idle");
    check("t1_gate_len", 64'(last_gate), 64'd10);
    check("t1_read_len", 64'(last_read), 64'd4);
    check("t1_frame_done", 64'(n_fd - fd0), 64'd1);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);

    // Backpressure 1-0-0-1.
    rdy_pat = 4'b1001;
    acc0 = n_acc;
    push_words(16'd0, 32'd5, 32'd1, 4);
    pulse_start(32'd10, 16'd1);
    wait_idle("t2_idle");
    check("t2_words", 64'(n_acc - acc0), 64'd4);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
    rdy_pat = 4'hF;

    // Three frames from the counter model.
    use_model = 1'b1;
    fd0 = n_fd;
    acc0 = n_acc;
    for (int f = 0; f < 3; f++) push_words(16'(f), 32'd10, 32'd10, 4);
    pulse_start(32'd10, 16'd3);
    wait_idle("t3_idle");
    check("t3_frame_done", 64'(n_fd - fd0), 64'd3);
    check("t3_words", 64'(n_acc - acc0), 64'd12);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // Free-run, stop during frame 5 drain.
    fd0 = n_fd;
    for (int f = 0; f < 6; f++) push_words(16'(f), 32'd3, 32'd3, 4);
    pulse_start(32'd3, 16'd0);
    n = 0;
    while (!(data_valid && data_frame == 16'd5) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t3b_reach_frame5", 64'(n < 3000), 64'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle("t3b_idle");
    check("t3b_frame_done", 64'(n_fd - fd0), 64'd6);
    check("t3b_queue_empty", 64'(exp_q.size()), 64'd0);

    // Stop on gate cycle 3 of 100.
    fd0 = n_fd;
    pulse_start(32'd100, 16'd1);
    n = 0;
    while (cnt_en_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_gate_open", 64'(n < 50), 64'd1);
    repeat (2) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t4_en_n_high", 64'(cnt_en_n), 64'd1);
    check("t4_busy_low", 64'(busy), 64'd0);
    repeat (10) @(negedge clk);
    check("t4_frame_done", 64'(n_fd - fd0), 64'd0);

    // gateLen = 0 acts as 1.
    push_words(16'd0, 32'd1, 32'd1, 4);
    pulse_start(32'd0, 16'd1);
    wait_idle("t5a_idle");
    check("t5a_gate_len", 64'(last_gate), 64'd1);
    check("t5a_queue_empty", 64'(exp_q.size()), 64'd0);

    // Start while busy is ignored.
    fd0 = n_fd;
    push_words(16'd0, 32'd20, 32'd20, 4);
    pulse_start(32'd20, 16'd1);
    repeat (5) @(negedge clk);
    pulse_start(32'd5, 16'd2);
    wait_idle("t5b_idle");
    check("t5b_gate_len", 64'(last_gate), 64'd20);
    check("t5b_frame_done", 64'(n_fd - fd0), 64'd1);
    check("t5b_queue_empty", 64'(exp_q.size()), 64'd0);

    // Start and stop together stay idle.
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    check("t5c_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    check("t5c_still_idle", {busy, cnt_rst, cnt_en_n}, {1'b0, 1'b0, 1'b1});

    // Reset mid-drain after ch1 accepted.
    use_model = 1'b0;
    push_words(16'd0, 32'd5, 32'd1, 2);
    pulse_start(32'd10, 16'd1);
    n = 0;
    while (!(data_valid && data_ready && data_ch == 4'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_ch1", 64'(n < 200), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("t6_reset_state");
    repeat (20) @(negedge clk);
    check("t6_idle_after_reset", 64'(busy), 64'd0);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    fd0 = n_fd;
    push_words(16'd0, 32'd5, 32'd1, 4);
    pulse_start(32'd10, 16'd1);
    wait_idle("t6_idle");
    check("t6_frame_done", 64'(n_fd - fd0), 64'd1);
    check("t6_queue_final", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
